// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: sequential instruction fetch with a small PC-tagged FIFO toward decode
// Optional feature: define IFB_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
// Ports:
//   clk, reset (async, active-low)
//   redirect, pc_in                          : flush and restart fetch at pc_in (word aligned)
//   imem_req, imem_addr, imem_gnt            : read request handshake, one read outstanding at most
//   imem_rvalid, imem_rdata                  : read response
//   instr_valid, instr_ready, instr, instr_pc: head of queue to decode
module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic          kill;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          resp, fifo_valid, bypass, push, pop;

    assign resp       = (state == WAIT) && imem_rvalid;
    assign fifo_valid = (count != '0);
`ifdef IFB_BYPASS_EN
    assign bypass     = !fifo_valid && !kill && !redirect && resp;
`else
    assign bypass     = 1'b0;
`endif
    // a bypassed word taken by decode in the same cycle never enters the FIFO
    assign push        = resp && !kill && !redirect && !(bypass && instr_ready);
    assign pop         = fifo_valid && instr_ready && !redirect;
    assign imem_req    = (state == REQ);
    assign instr_valid = fifo_valid || bypass;
    assign instr       = bypass ? imem_rdata : mem_data[rd_ptr];
    assign instr_pc    = bypass ? imem_addr  : mem_pc[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // count alone gates the request: nothing is outstanding while in IDLE
    always_comb begin
        state_nxt = state;
        if (state == IDLE && count < FULL && !redirect) state_nxt = REQ;
        if (state == REQ && imem_gnt)                   state_nxt = WAIT;
        if (resp)                                       state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= '0;
            kill      <= 1'b0;
        end else begin
            // once killed, the grant belongs to the stale address and must not advance the new target
            if (redirect)                                fetch_pc <= pc_in & ~32'h3;
            else if (state == REQ && imem_gnt && !kill)  fetch_pc <= fetch_pc + 32'd4;
            if (state == IDLE && state_nxt == REQ)       imem_addr <= fetch_pc;
            // a redirect landing on the response itself drops it directly, no kill needed
            kill <= resp ? 1'b0 : (kill || (redirect && state != IDLE));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= imem_rdata;
                mem_pc[wr_ptr]   <= imem_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
endmodule
